// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, FSM state
// encoding, bus source codes, ALU op codes and the decoded IR field layout.
// Build option CTRL_UNIT_SHIFT_EN (see ctrl_unit) adds the shl form of op 000.
package ctrl_pkg;

  // opcodes, IR[15:13]
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_BZ  = 3'b111;

  // FSM state encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  // bus source codes beyond the register file (0-7 select R0..R7)
  localparam logic [3:0] BUS_PC  = 4'd7;
  localparam logic [3:0] BUS_G   = 4'd8;
  localparam logic [3:0] BUS_DIN = 4'd9;

  // ALU op codes
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       sh;
    logic [3:0] amt;
  } irFields_t;

endpackage

// File: rtl/ctrl_irdec.sv
// Combinational IR field splitter plus one-hot decode of the Rx field.
module ctrl_irdec
  import ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output irFields_t   fld,
  output logic [7:0]  rxOneHot
);

  assign fld.op  = ir[15:13];
  assign fld.rx  = ir[12:10];
  assign fld.ry  = ir[9:7];
  assign fld.sh  = ir[6];
  assign fld.amt = ir[3:0];

  // Rx as a register write-enable mask
  assign rxOneHot = 8'b1 << fld.rx;

  // IR[5:4] carry no meaning for any instruction
  logic unusedBits;
  assign unusedBits = ^ir[5:4];

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: fetch (T0/T1), decode from the IR (T2 onward),
// and sequencing of register file, RA/G latches, memory and ALU.
// Define CTRL_UNIT_SHIFT_EN to execute op 000 with sh=1 as shl; otherwise
// op 000 is always mv and ShAmt stays 0.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 16  // only 16 is supported
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Zero,
  output logic              IRin,
  output logic [7:0]        Rin,
  output logic [3:0]        BusSel,
  output logic              Ain,
  output logic              Gin,
  output logic [2:0]        AluOp,
  output logic [3:0]        ShAmt,
  output logic              AddrIn,
  output logic              PcIncr,
  output logic              DoutIn,
  output logic              WrEn,
  output logic              Done
);

  logic [2:0]  state, nxt;
  logic [15:0] ir;
  logic        zFlag;
  irFields_t   fld;
  logic [7:0]  rxOneHot;

  ctrl_irdec uDec (.ir(ir), .fld(fld), .rxOneHot(rxOneHot));

`ifndef CTRL_UNIT_SHIFT_EN
  // sh and amt only matter for the shl form
  logic unusedCfg;
  assign unusedCfg = ^{fld.sh, fld.amt};
`endif

  // state, instruction register and zero flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      ir    <= '0;
      zFlag <= 1'b0;
    end else begin
      state <= nxt;
      if (IRin) ir <= DIN;
      if (Gin)  zFlag <= Zero;
    end
  end

  // per-state control outputs and next-state selection
  always_comb begin
    nxt    = state;
    IRin   = 1'b0;
    Rin    = '0;
    BusSel = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AluOp  = ALU_NOP;
    ShAmt  = '0;
    AddrIn = 1'b0;
    PcIncr = 1'b0;
    DoutIn = 1'b0;
    WrEn   = 1'b0;
    Done   = 1'b0;
    if (!Reset) begin
      case (state)
        S_IDLE: if (Run) nxt = S_T0;
        S_T0: begin
          BusSel = BUS_PC; AddrIn = 1'b1; PcIncr = 1'b1; nxt = S_T1;
        end
        S_T1: begin
          IRin = 1'b1; nxt = S_T2;
        end
        S_T2: begin
          nxt = S_T3;
          case (fld.op)
            OP_MV:
`ifdef CTRL_UNIT_SHIFT_EN
              if (fld.sh) begin
                BusSel = {1'b0, fld.ry}; AluOp = ALU_PASS; ShAmt = fld.amt; Gin = 1'b1;
              end else
`endif
              begin
                BusSel = {1'b0, fld.ry}; Rin = rxOneHot; Done = 1'b1;
              end
            OP_MVI: begin
              BusSel = BUS_PC; AddrIn = 1'b1; PcIncr = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              BusSel = {1'b0, fld.rx}; Ain = 1'b1;
            end
            OP_LD, OP_ST: begin
              BusSel = {1'b0, fld.ry}; AddrIn = 1'b1;
            end
            default: begin  // bz: PC <- Rx when the last ALU result was zero
              Done = 1'b1;
              if (zFlag) begin
                BusSel = {1'b0, fld.rx}; Rin = 8'h80;
              end
            end
          endcase
        end
        S_T3: begin
          nxt = S_T4;
          case (fld.op)
`ifdef CTRL_UNIT_SHIFT_EN
            OP_MV: if (fld.sh) begin
              BusSel = BUS_G; Rin = rxOneHot; Done = 1'b1;
            end
`endif
            OP_ADD, OP_SUB, OP_AND: begin
              BusSel = {1'b0, fld.ry}; Gin = 1'b1;
              AluOp = (fld.op == OP_ADD) ? ALU_ADD :
                      (fld.op == OP_SUB) ? ALU_SUB : ALU_AND;
            end
            OP_ST: begin
              BusSel = {1'b0, fld.rx}; DoutIn = 1'b1; WrEn = 1'b1; Done = 1'b1;
            end
            default: ;  // mvi/ld wait for memory data
          endcase
        end
        S_T4: begin
          nxt = S_IDLE;
          case (fld.op)
            OP_MVI, OP_LD: begin
              BusSel = BUS_DIN; Rin = rxOneHot; Done = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              BusSel = BUS_G; Rin = rxOneHot; Done = 1'b1;
            end
            default: ;
          endcase
        end
        default: nxt = S_IDLE;
      endcase
      // chain straight into the next fetch while Run is held
      if (Done) nxt = Run ? S_T0 : S_IDLE;
    end
  end

endmodule
